// File: rtl/axi4_dual_master_arbiter_pkg.sv
// Shared types and width helpers for the dual-master AXI4 arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // AW/AR payload: {id, addr, len[7:0], size[2:0], burst[1:0]}
   function automatic int ax_w(input int id_w, input int addr_w);
      return id_w + addr_w + 8 + 3 + 2;
   endfunction

   // W payload: {data, strb, last}
   function automatic int w_w(input int data_w);
      return data_w + data_w / 8 + 1;
   endfunction

   // R payload: {data, resp, last}
   function automatic int r_w(input int data_w);
      return data_w + 2 + 1;
   endfunction

endpackage

// File: rtl/axi4_dual_master_arbiter_if.sv
// Bundle of all handshake/payload signals around the arbiter.
// slave  : the arbiter's own view (it is the slave of both upstream masters).
// master : the surrounding view (upstream masters plus the downstream slave).
interface axi4_dual_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   import axi_arb_pkg::*;

   localparam int AW_W = ax_w(ID_W, ADDR_W);
   localparam int AR_W = ax_w(ID_W, ADDR_W);
   localparam int W_W  = w_w(DATA_W);
   localparam int R_W  = r_w(DATA_W);

   logic [1:0]        s_awvalid;
   logic [1:0]        s_awready;
   logic [2*AW_W-1:0] s_aw;
   logic [1:0]        s_wvalid;
   logic [1:0]        s_wready;
   logic [2*W_W-1:0]  s_w;
   logic [1:0]        s_bvalid;
   logic [1:0]        s_bready;
   logic [1:0]        s_bresp;
   logic [1:0]        s_arvalid;
   logic [1:0]        s_arready;
   logic [2*AR_W-1:0] s_ar;
   logic [1:0]        s_rvalid;
   logic [1:0]        s_rready;
   logic [R_W-1:0]    s_r;

   logic              m_awvalid;
   logic              m_awready;
   logic [AW_W-1:0]   m_aw;
   logic              m_wvalid;
   logic              m_wready;
   logic [W_W-1:0]    m_w;
   logic              m_bvalid;
   logic              m_bready;
   logic [1:0]        m_bresp;
   logic              m_arvalid;
   logic              m_arready;
   logic [AR_W-1:0]   m_ar;
   logic              m_rvalid;
   logic              m_rready;
   logic [R_W-1:0]    m_r;

   logic [1:0]        wr_gnt;
   logic [1:0]        rd_gnt;

   modport slave (
      input  s_awvalid, s_aw, s_wvalid, s_w, s_bready, s_arvalid, s_ar, s_rready,
      input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_r,
      output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_r,
      output m_awvalid, m_aw, m_wvalid, m_w, m_bready, m_arvalid, m_ar, m_rready,
      output wr_gnt, rd_gnt
   );

   modport master (
      output s_awvalid, s_aw, s_wvalid, s_w, s_bready, s_arvalid, s_ar, s_rready,
      output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_r,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_r,
      input  m_awvalid, m_aw, m_wvalid, m_w, m_bready, m_arvalid, m_ar, m_rready,
      input  wr_gnt, rd_gnt
   );

endinterface

// File: rtl/axi4_dual_master_arbiter_rr_arb2.sv
// Two-way round-robin picker. Grant is combinational from the request
// vector; the preference pointer only moves when a transaction completes,
// and then points away from the port that just finished.
module axi_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   input  logic       done_idx_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   // next preference: the other port once the current owner is done
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) ptr_d = ~done_idx_i;
   end

   // preference register, favours port 0 out of reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end

   // lone requester wins; on a tie the pointed-to port wins
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi4_dual_master_arbiter.sv
// Shares one AXI4 master port between two upstream masters. Write and read
// directions run independent FSMs, each with one outstanding transaction,
// so IDs pass through untouched. The grant is frozen outside IDLE, which
// keeps every forwarded valid/payload stable until its handshake.
module axi4_dual_master_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic ACLK,
   input  logic ARESET,
   axi4_dual_master_arbiter_if.slave bus
);
   import axi_arb_pkg::*;

   localparam int AW_W = ax_w(ID_W, ADDR_W);
   localparam int AR_W = ax_w(ID_W, ADDR_W);
   localparam int W_W  = w_w(DATA_W);

   wr_state_t  wr_state_q, wr_state_d;
   logic [1:0] wr_gnt_q, wr_gnt_d;
   logic [1:0] wr_arb_gnt;
   logic       wr_sel;
   logic       wr_done;
   logic [W_W-1:0] w_sel;

   rd_state_t  rd_state_q, rd_state_d;
   logic [1:0] rd_gnt_q, rd_gnt_d;
   logic [1:0] rd_arb_gnt;
   logic       rd_sel;
   logic       rd_done;

   assign wr_sel = wr_gnt_q[1];
   assign rd_sel = rd_gnt_q[1];

   axi_rr_arb2 u_wr_arb (
      .clk_i      (ACLK),
      .rst_i      (ARESET),
      .req_i      (bus.s_awvalid),
      .advance_i  (wr_done),
      .done_idx_i (wr_sel),
      .gnt_o      (wr_arb_gnt)
   );

   axi_rr_arb2 u_rd_arb (
      .clk_i      (ACLK),
      .rst_i      (ARESET),
      .req_i      (bus.s_arvalid),
      .advance_i  (rd_done),
      .done_idx_i (rd_sel),
      .gnt_o      (rd_arb_gnt)
   );

   // payload muxes follow the registered grant; responses are broadcast
   assign w_sel       = wr_sel ? bus.s_w[2*W_W-1:W_W]    : bus.s_w[W_W-1:0];
   assign bus.m_w     = w_sel;
   assign bus.m_aw    = wr_sel ? bus.s_aw[2*AW_W-1:AW_W] : bus.s_aw[AW_W-1:0];
   assign bus.m_ar    = rd_sel ? bus.s_ar[2*AR_W-1:AR_W] : bus.s_ar[AR_W-1:0];
   assign bus.s_bresp = bus.m_bresp;
   assign bus.s_r     = bus.m_r;
   assign bus.wr_gnt  = wr_gnt_q;
   assign bus.rd_gnt  = rd_gnt_q;

   // write path state and owner registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state_q <= W_IDLE;
         wr_gnt_q   <= 2'b00;
      end else begin
         wr_state_q <= wr_state_d;
         wr_gnt_q   <= wr_gnt_d;
      end
   end

   // write path next state and handshake routing
   always_comb begin
      wr_state_d    = wr_state_q;
      wr_gnt_d      = wr_gnt_q;
      wr_done       = 1'b0;
      bus.m_awvalid = 1'b0;
      bus.s_awready = 2'b00;
      bus.m_wvalid  = 1'b0;
      bus.s_wready  = 2'b00;
      bus.s_bvalid  = 2'b00;
      bus.m_bready  = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (|bus.s_awvalid) begin
               wr_gnt_d   = wr_arb_gnt;
               wr_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            bus.m_awvalid         = bus.s_awvalid[wr_sel];
            bus.s_awready[wr_sel] = bus.m_awready;
            if (bus.s_awvalid[wr_sel] && bus.m_awready) wr_state_d = W_DATA;
         end
         W_DATA: begin
            bus.m_wvalid         = bus.s_wvalid[wr_sel];
            bus.s_wready[wr_sel] = bus.m_wready;
            if (bus.s_wvalid[wr_sel] && bus.m_wready && w_sel[0]) wr_state_d = W_RESP;
         end
         W_RESP: begin
            bus.s_bvalid[wr_sel] = bus.m_bvalid;
            bus.m_bready         = bus.s_bready[wr_sel];
            if (bus.m_bvalid && bus.s_bready[wr_sel]) begin
               wr_done    = 1'b1;
               wr_gnt_d   = 2'b00;
               wr_state_d = W_IDLE;
            end
         end
         default: begin
            wr_gnt_d   = 2'b00;
            wr_state_d = W_IDLE;
         end
      endcase
   end

   // read path state and owner registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state_q <= R_IDLE;
         rd_gnt_q   <= 2'b00;
      end else begin
         rd_state_q <= rd_state_d;
         rd_gnt_q   <= rd_gnt_d;
      end
   end

   // read path next state and handshake routing
   always_comb begin
      rd_state_d    = rd_state_q;
      rd_gnt_d      = rd_gnt_q;
      rd_done       = 1'b0;
      bus.m_arvalid = 1'b0;
      bus.s_arready = 2'b00;
      bus.s_rvalid  = 2'b00;
      bus.m_rready  = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (|bus.s_arvalid) begin
               rd_gnt_d   = rd_arb_gnt;
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            bus.m_arvalid         = bus.s_arvalid[rd_sel];
            bus.s_arready[rd_sel] = bus.m_arready;
            if (bus.s_arvalid[rd_sel] && bus.m_arready) rd_state_d = R_DATA;
         end
         R_DATA: begin
            bus.s_rvalid[rd_sel] = bus.m_rvalid;
            bus.m_rready         = bus.s_rready[rd_sel];
            if (bus.m_rvalid && bus.s_rready[rd_sel] && bus.m_r[0]) begin
               rd_done    = 1'b1;
               rd_gnt_d   = 2'b00;
               rd_state_d = R_IDLE;
            end
         end
         default: begin
            rd_gnt_d   = 2'b00;
            rd_state_d = R_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4_dual_master_arbiter.sv
// Directed bench for the dual-master AXI4 arbiter. The bench plays both
// upstream masters and the downstream slave. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 unit later.
module tb_axi4_dual_master_arbiter;
   import axi_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int AW_W   = ax_w(ID_W, ADDR_W);
   localparam int W_W    = w_w(DATA_W);
   localparam int R_W    = r_w(DATA_W);

   logic ACLK   = 1'b0;
   logic ARESET = 1'b1;

   int n_cmp   = 0;
   int n_err   = 0;
   int wbeats  = 0;
   int rbeats1 = 0;
   int rlast1  = 0;

   logic [AW_W-1:0] aw_p [2];
   logic [AW_W-1:0] ar1;

   axi4_dual_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

   axi4_dual_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   // beat counters, sampled mid-cycle so they see the values present at the next edge
   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (bus.m_wvalid && bus.m_wready) wbeats++;
         if (bus.s_rvalid[1] && bus.s_rready[1]) begin
            rbeats1++;
            if (bus.s_r[0]) rlast1++;
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [AW_W-1:0] mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                             input logic [7:0] len);
      return {id, addr, len, 3'd2, 2'b01};
   endfunction

   task automatic idle_inputs();
      bus.s_awvalid = 2'b00;  bus.s_aw = '0;
      bus.s_wvalid  = 2'b00;  bus.s_w  = '0;
      bus.s_bready  = 2'b00;
      bus.s_arvalid = 2'b00;  bus.s_ar = '0;
      bus.s_rready  = 2'b00;
      bus.m_awready = 1'b0;   bus.m_wready = 1'b0;
      bus.m_bvalid  = 1'b0;   bus.m_bresp  = 2'b00;
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;   bus.m_r      = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      ARESET = 1'b1;
      step();
      step();
      ARESET = 1'b0;
      step();
   endtask

   task automatic set_aw(input int p, input logic [AW_W-1:0] v);
      aw_p[p] = v;
      bus.s_aw = {aw_p[1], aw_p[0]};
   endtask

   task automatic drive_w(input int p, input logic [W_W-1:0] v);
      if (p == 1) bus.s_w[2*W_W-1:W_W] = v;
      else        bus.s_w[W_W-1:0]     = v;
   endtask

   // full write for port p; s_awvalid[p] must already be high with the FSM idle
   task automatic wr_txn(input int p, input int beats, input logic [1:0] resp,
                         input logic [31:0] d0, input int stall_beat);
      logic [1:0]     pm;
      logic [W_W-1:0] wpay;
      pm = (p == 1) ? 2'b10 : 2'b01;
      settle();
      check_val("aw_latency_idle", 64'(bus.m_awvalid), 64'd0);
      step();
      check_val("wr_gnt_addr", 64'(bus.wr_gnt), 64'(pm));
      check_val("m_awvalid", 64'(bus.m_awvalid), 64'd1);
      check_val("m_aw_payload", 64'(bus.m_aw), 64'(aw_p[p]));
      bus.m_awready = 1'b1;
      settle();
      check_val("s_awready_owner", 64'(bus.s_awready), 64'(pm));
      step();
      bus.s_awvalid[p] = 1'b0;
      bus.m_awready    = 1'b0;
      bus.m_wready     = 1'b1;
      for (int b = 0; b < beats; b++) begin
         wpay = {32'(d0 + 32'(b)), 4'hF, (b == beats - 1)};
         bus.s_wvalid[p] = 1'b1;
         drive_w(p, wpay);
         if (b == stall_beat) begin
            bus.m_wready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               settle();
               check_val("w_stall_payload", 64'(bus.m_w), 64'(wpay));
               check_val("w_stall_ready", 64'(bus.s_wready), 64'd0);
               step();
            end
            bus.m_wready = 1'b1;
         end
         settle();
         check_val("m_wvalid", 64'(bus.m_wvalid), 64'd1);
         check_val("m_w_payload", 64'(bus.m_w), 64'(wpay));
         check_val("s_wready_owner", 64'(bus.s_wready), 64'(pm));
         check_val("wr_gnt_data", 64'(bus.wr_gnt), 64'(pm));
         step();
      end
      bus.s_wvalid[p] = 1'b0;
      bus.m_wready    = 1'b0;
      bus.m_bvalid    = 1'b1;
      bus.m_bresp     = resp;
      bus.s_bready    = 2'b11;
      settle();
      check_val("s_bvalid_owner", 64'(bus.s_bvalid), 64'(pm));
      check_val("s_bresp", 64'(bus.s_bresp), 64'(resp));
      check_val("m_bready", 64'(bus.m_bready), 64'd1);
      step();
      bus.m_bvalid = 1'b0;
      bus.s_bready = 2'b00;
      settle();
      check_val("wr_gnt_released", 64'(bus.wr_gnt), 64'd0);
      check_val("s_bvalid_idle", 64'(bus.s_bvalid), 64'd0);
   endtask

   // full read for port 1; s_arvalid[1] must already be high with the FSM idle
   task automatic rd_txn1(input int beats, input logic [31:0] d0);
      logic [R_W-1:0] rpay;
      settle();
      check_val("ar_latency_idle", 64'(bus.m_arvalid), 64'd0);
      step();
      check_val("rd_gnt_addr", 64'(bus.rd_gnt), 64'd2);
      check_val("m_arvalid", 64'(bus.m_arvalid), 64'd1);
      check_val("m_ar_payload", 64'(bus.m_ar), 64'(ar1));
      bus.m_arready = 1'b1;
      settle();
      check_val("s_arready_owner", 64'(bus.s_arready), 64'd2);
      step();
      bus.s_arvalid[1] = 1'b0;
      bus.m_arready    = 1'b0;
      bus.s_rready     = 2'b10;
      for (int b = 0; b < beats; b++) begin
         rpay = {32'(d0 + 32'(b)), RESP_OKAY, (b == beats - 1)};
         bus.m_rvalid = 1'b1;
         bus.m_r      = rpay;
         settle();
         check_val("s_rvalid_owner", 64'(bus.s_rvalid), 64'd2);
         check_val("s_r_payload", 64'(bus.s_r), 64'(rpay));
         check_val("m_rready", 64'(bus.m_rready), 64'd1);
         check_val("rd_gnt_data", 64'(bus.rd_gnt), 64'd2);
         step();
      end
      bus.m_rvalid = 1'b0;
      bus.s_rready = 2'b00;
      settle();
      check_val("rd_gnt_released", 64'(bus.rd_gnt), 64'd0);
   endtask

   initial begin
      aw_p[0] = '0;
      aw_p[1] = '0;
      ar1     = '0;
      idle_inputs();
      ARESET = 1'b1;
      step();
      step();

      // reset state
      check_val("rst_wr_gnt", 64'(bus.wr_gnt), 64'd0);
      check_val("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
      check_val("rst_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.s_bvalid, bus.s_rvalid}), 64'd0);
      check_val("rst_readys", 64'({bus.s_awready, bus.s_wready, bus.s_arready, bus.m_bready, bus.m_rready}), 64'd0);
      ARESET = 1'b0;
      step();

      // stray responses while idle are never acknowledged
      bus.m_bvalid = 1'b1;
      bus.m_rvalid = 1'b1;
      bus.s_bready = 2'b11;
      bus.s_rready = 2'b11;
      settle();
      check_val("stray_m_bready", 64'(bus.m_bready), 64'd0);
      check_val("stray_m_rready", 64'(bus.m_rready), 64'd0);
      check_val("stray_s_valids", 64'({bus.s_bvalid, bus.s_rvalid}), 64'd0);
      step();
      idle_inputs();
      step();

      // 1: single port-0 write, addr 0x100, data 0xDEADBEEF
      set_aw(0, mk_ax(4'h1, 32'h0000_0100, 8'd0));
      bus.s_awvalid[0] = 1'b1;
      wr_txn(0, 1, RESP_OKAY, 32'hDEAD_BEEF, -1);

      // 2: simultaneous AW after reset, port 0 then port 1, twice
      do_reset();
      set_aw(0, mk_ax(4'h2, 32'h0000_0200, 8'd0));
      set_aw(1, mk_ax(4'h3, 32'h0000_0300, 8'd0));
      bus.s_awvalid = 2'b11;
      wr_txn(0, 1, RESP_OKAY, 32'h1111_0000, -1);
      wr_txn(1, 1, RESP_OKAY, 32'h2222_0000, -1);
      bus.s_awvalid = 2'b11;
      wr_txn(0, 1, RESP_OKAY, 32'h3333_0000, -1);
      wr_txn(1, 1, RESP_OKAY, 32'h4444_0000, -1);

      // 3: port-1 4-beat read concurrent with a port-0 write
      rbeats1 = 0;
      rlast1  = 0;
      set_aw(0, mk_ax(4'h4, 32'h0000_0400, 8'd1));
      ar1 = mk_ax(4'h5, 32'h0000_0500, 8'd3);
      bus.s_ar = {ar1, {AW_W{1'b0}}};
      bus.s_awvalid[0] = 1'b1;
      bus.s_arvalid[1] = 1'b1;
      fork
         wr_txn(0, 2, RESP_OKAY, 32'h5555_0000, -1);
         rd_txn1(4, 32'hA000_0000);
      join
      check_val("rd_beats_port1", 64'(rbeats1), 64'd4);
      check_val("rd_last_port1", 64'(rlast1), 64'd1);

      // 4: m_wready stalls 5 cycles mid-burst while port 1 waits on AW
      do_reset();
      wbeats = 0;
      set_aw(0, mk_ax(4'h6, 32'h0000_0600, 8'd2));
      set_aw(1, mk_ax(4'h7, 32'h0000_0700, 8'd0));
      bus.s_awvalid = 2'b11;
      wr_txn(0, 3, RESP_OKAY, 32'hC0DE_0000, 1);
      check_val("w_beats_stall", 64'(wbeats), 64'd3);
      wr_txn(1, 1, RESP_OKAY, 32'hBEEF_0000, -1);

      // 5: SLVERR passes through to port 0 unmodified
      set_aw(0, mk_ax(4'h8, 32'h0000_0800, 8'd1));
      bus.s_awvalid[0] = 1'b1;
      wr_txn(0, 2, RESP_SLVERR, 32'h0BAD_0000, -1);

      // 6: reset asserted during W beat 2, then a clean port-1 write
      set_aw(0, mk_ax(4'h9, 32'h0000_0900, 8'd3));
      bus.s_awvalid[0] = 1'b1;
      step();
      bus.m_awready = 1'b1;
      step();
      bus.s_awvalid    = 2'b00;
      bus.m_awready    = 1'b0;
      bus.s_wvalid[0]  = 1'b1;
      bus.m_wready     = 1'b1;
      drive_w(0, {32'h7777_0000, 4'hF, 1'b0});
      step();
      drive_w(0, {32'h7777_0001, 4'hF, 1'b0});
      settle();
      check_val("pre_rst_m_wvalid", 64'(bus.m_wvalid), 64'd1);
      ARESET = 1'b1;
      settle();
      check_val("mid_rst_m_wvalid", 64'(bus.m_wvalid), 64'd0);
      check_val("mid_rst_s_wready", 64'(bus.s_wready), 64'd0);
      check_val("mid_rst_wr_gnt", 64'(bus.wr_gnt), 64'd0);
      idle_inputs();
      step();
      ARESET = 1'b0;
      step();
      set_aw(1, mk_ax(4'hA, 32'h0000_0A00, 8'd0));
      bus.s_awvalid[1] = 1'b1;
      wr_txn(1, 1, RESP_OKAY, 32'h900D_0000, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // hard stop in case a task ever waits forever
   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

endmodule
